// File: rtl/cpu_pkg.sv
// Shared datapath types and fetch-state encoding for the 8-bit CPU.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t HALT_WORD_DEFAULT = 8'hFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, latches memory data into ir and hands it
// to decode over valid/ready, with branch redirect and halt handling.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter addr_t  RESET_PC  = 8'h00,
    parameter instr_t HALT_WORD = HALT_WORD_DEFAULT,
    parameter instr_t HALT_MASK = 8'hFF,
    parameter int     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    output addr_t            pc,
    input  instr_t           instructions,
    output instr_t           ir,
    output addr_t            ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             redirect,
    input  addr_t            redirect_target,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t state;
    logic         adv;
    logic         is_halt;

    assign adv     = (state == RUN) && (!ir_valid || ir_ready) && !redirect;
    assign is_halt = (instructions & HALT_MASK) == (HALT_WORD & HALT_MASK);
    assign halted  = (state == HALT);

    // Redirect outranks fetch so a taken branch always flushes the stale ir,
    // even when decode is accepting it in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (redirect) begin
            state    <= RUN;
            pc       <= redirect_target;
            ir_valid <= 1'b0;
        end else if (adv) begin
            ir       <= instructions;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (is_halt) begin
                state <= HALT;
            end else begin
                pc <= pc + addr_t'(1);
            end
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_fetch_count (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .count (fetch_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model plus directed
// vectors with hand-computed expectations.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    addr_t       pc;
    instr_t      instructions;
    instr_t      ir;
    addr_t       ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    addr_t       redirect_target;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  mem [256];

    int tests;
    int fails;

    logic [7:0]  m_pc;
    logic [7:0]  m_ir;
    logic [7:0]  m_ir_pc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;

    fetch_stage #(
        .RESET_PC  (8'h00),
        .HALT_WORD (8'hFF),
        .HALT_MASK (8'hFF),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .instructions    (instructions),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    assign instructions = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic rd, input logic [7:0] tgt);
        ir_ready        = rdy;
        redirect        = rd;
        redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Transaction model: each edge is exactly one of redirect, fetch, drain or hold.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc     = 8'h00;
            m_ir     = 8'h00;
            m_ir_pc  = 8'h00;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_count  = 16'h0000;
        end else if (redirect) begin
            m_pc     = redirect_target;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (!m_halted && (!m_valid || ir_ready)) begin
            m_ir    = mem[m_pc];
            m_ir_pc = m_pc;
            m_valid = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (m_ir == 8'hFF) m_halted = 1'b1;
            else               m_pc = (m_pc + 8'd1) % 256;
        end else if (m_valid && ir_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        checkOutput("model_pc",       {24'h0, pc},          {24'h0, m_pc});
        checkOutput("model_ir",       {24'h0, ir},          {24'h0, m_ir});
        checkOutput("model_ir_pc",    {24'h0, ir_pc},       {24'h0, m_ir_pc});
        checkOutput("model_ir_valid", {31'h0, ir_valid},    {31'h0, m_valid});
        checkOutput("model_halted",   {31'h0, halted},      {31'h0, m_halted});
        checkOutput("model_count",    {16'h0, fetch_count}, {16'h0, m_count});
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, i[6:0]};
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        mem[8'h04] = 8'h55;
        mem[8'h05] = 8'hFF;
        mem[8'h80] = 8'h3C;
        mem[8'hFF] = 8'h10;

        reset           = 1'b1;
        ir_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_pc",       {24'h0, pc},          32'h00);
        checkOutput("rst_ir_valid", {31'h0, ir_valid},    32'h0);
        checkOutput("rst_count",    {16'h0, fetch_count}, 32'h0);
        checkOutput("rst_halted",   {31'h0, halted},      32'h0);

        // First instruction one edge after reset release
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("first_valid", {31'h0, ir_valid}, 32'h1);
        checkOutput("first_ir",    {24'h0, ir},       32'h11);
        checkOutput("first_ir_pc", {24'h0, ir_pc},    32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("second_ir",    {24'h0, ir},    32'h22);
        checkOutput("second_ir_pc", {24'h0, ir_pc}, 32'h01);

        // Stall three cycles on 0x22
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("stall_ir",    {24'h0, ir},       32'h22);
        checkOutput("stall_ir_pc", {24'h0, ir_pc},    32'h01);
        checkOutput("stall_pc",    {24'h0, pc},       32'h02);
        checkOutput("stall_valid", {31'h0, ir_valid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("resume_ir",    {24'h0, ir},          32'h33);
        checkOutput("resume_ir_pc", {24'h0, ir_pc},       32'h02);
        checkOutput("resume_count", {16'h0, fetch_count}, 32'h3);

        // Redirect flushes a valid ir that decode is also accepting
        applyStimulus(1'b1, 1'b1, 8'h80);
        checkOutput("redir_valid", {31'h0, ir_valid},    32'h0);
        checkOutput("redir_pc",    {24'h0, pc},          32'h80);
        checkOutput("redir_count", {16'h0, fetch_count}, 32'h3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("redir_ir",    {24'h0, ir},    32'h3C);
        checkOutput("redir_ir_pc", {24'h0, ir_pc}, 32'h80);

        // PC wrap from 0xFF
        applyStimulus(1'b1, 1'b1, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("wrap_ir_pc", {24'h0, ir_pc}, 32'hFF);
        checkOutput("wrap_ir",    {24'h0, ir},    32'h10);
        checkOutput("wrap_pc",    {24'h0, pc},    32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("wrap_next_ir_pc", {24'h0, ir_pc}, 32'h00);
        checkOutput("wrap_count", {16'h0, fetch_count}, 32'h6);

        // Halt at 0x05
        applyStimulus(1'b1, 1'b1, 8'h04);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("halt_ir",     {24'h0, ir},          32'hFF);
        checkOutput("halt_ir_pc",  {24'h0, ir_pc},       32'h05);
        checkOutput("halt_flag",   {31'h0, halted},      32'h1);
        checkOutput("halt_pc",     {24'h0, pc},          32'h05);
        checkOutput("halt_valid",  {31'h0, ir_valid},    32'h1);
        checkOutput("halt_count",  {16'h0, fetch_count}, 32'h8);
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("halt_hold_valid", {31'h0, ir_valid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("halt_drain_valid", {31'h0, ir_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("halt_stay_pc",    {24'h0, pc},          32'h05);
        checkOutput("halt_stay_flag",  {31'h0, halted},      32'h1);
        checkOutput("halt_stay_count", {16'h0, fetch_count}, 32'h8);
        applyStimulus(1'b1, 1'b1, 8'h20);
        checkOutput("unhalt_flag", {31'h0, halted}, 32'h0);
        checkOutput("unhalt_pc",   {24'h0, pc},     32'h20);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("unhalt_ir_pc", {24'h0, ir_pc},       32'h20);
        checkOutput("unhalt_count", {16'h0, fetch_count}, 32'h9);

        // Async reset mid-cycle while stalled at pc 0x42
        applyStimulus(1'b1, 1'b1, 8'h41);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pre_rst_pc", {24'h0, pc}, 32'h42);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_pc",    {24'h0, pc},          32'h00);
        checkOutput("async_valid", {31'h0, ir_valid},    32'h0);
        checkOutput("async_ir",    {24'h0, ir},          32'h00);
        checkOutput("async_ir_pc", {24'h0, ir_pc},       32'h00);
        checkOutput("async_count", {16'h0, fetch_count}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Mixed ready/redirect traffic covered by the model
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), (i % 13) == 12, 8'($urandom_range(0, 255)));
        end
        applyStimulus(1'b1, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
